// File: rtl/array_access_sched.sv
// Scheduler for the shared DRAM-array port. It generates periodic refresh demands,
// grants the array to one of write/read/refresh, and muxes the owner's controls.
`timescale 1ns/1ps

module array_access_sched #(
    parameter int AXI_RADDR_WIDTH = 14,
    parameter int AXI_CADDR_WIDTH = 6,
    parameter int RF_PEND_MAX     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [15:0]                mc_trefi_cfg,
    input  logic                       wr_req,
    input  logic                       rd_req,
    input  logic                       wr_done,
    input  logic                       rd_done,
    input  logic                       rf_done,
    output logic                       wr_grant,
    output logic                       rd_grant,
    output logic                       rf_grant,
    output logic [3:0]                 rf_pend_cnt,
    output logic                       rf_overflow,
    input  logic                       banksel_n_wr,
    input  logic [AXI_RADDR_WIDTH-1:0] raddr_wr,
    input  logic                       cas_wr,
    input  logic [AXI_CADDR_WIDTH-1:0] caddr_wr,
    input  logic                       banksel_n_rd,
    input  logic [AXI_RADDR_WIDTH-1:0] raddr_rd,
    input  logic                       cas_rd,
    input  logic [AXI_CADDR_WIDTH-1:0] caddr_rd,
    input  logic                       banksel_n_rf,
    input  logic [AXI_RADDR_WIDTH-1:0] raddr_rf,
    output logic                       array_banksel_n,
    output logic [AXI_RADDR_WIDTH-1:0] array_raddr,
    output logic                       array_cas,
    output logic [AXI_CADDR_WIDTH-1:0] array_caddr,
    output logic                       array_we
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RF
    } state_t;

    localparam logic [3:0] PEND_MAX = 4'(RF_PEND_MAX);

    state_t      state;
    logic        rr_rd;       // 1: read wins the next write/read tie
    logic [15:0] trefi_cnt;
    logic        rf_tick;
    logic        rf_take;

    assign rf_tick = (mc_trefi_cfg != 16'd0) && (trefi_cnt == mc_trefi_cfg - 16'd1);
    // Refresh always wins arbitration, so any queued refresh is taken from IDLE.
    assign rf_take = (state == S_IDLE) && (rf_pend_cnt != 4'd0);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of the order of the always_ff blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trefi_cnt <= 16'd0;
        end else if (mc_trefi_cfg == 16'd0 || rf_tick) begin
            trefi_cnt <= 16'd0;
        end else begin
            trefi_cnt <= trefi_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_pend_cnt <= 4'd0;
            rf_overflow <= 1'b0;
        end else begin
            case ({rf_tick, rf_take})
                2'b10: begin
                    if (rf_pend_cnt == PEND_MAX) begin
                        rf_overflow <= 1'b1;
                    end else begin
                        rf_pend_cnt <= rf_pend_cnt + 4'd1;
                    end
                end
                2'b01:   rf_pend_cnt <= rf_pend_cnt - 4'd1;
                default: rf_pend_cnt <= rf_pend_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rr_rd    <= 1'b0;
            wr_grant <= 1'b0;
            rd_grant <= 1'b0;
            rf_grant <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rf_take) begin
                        state    <= S_RF;
                        rf_grant <= 1'b1;
                    end else if (wr_req && rd_req) begin
                        rr_rd <= ~rr_rd;
                        if (rr_rd) begin
                            state    <= S_RD;
                            rd_grant <= 1'b1;
                        end else begin
                            state    <= S_WR;
                            wr_grant <= 1'b1;
                        end
                    end else if (wr_req) begin
                        state    <= S_WR;
                        wr_grant <= 1'b1;
                    end else if (rd_req) begin
                        state    <= S_RD;
                        rd_grant <= 1'b1;
                    end
                end
                S_WR: begin
                    if (wr_done) begin
                        state    <= S_IDLE;
                        wr_grant <= 1'b0;
                    end
                end
                S_RD: begin
                    if (rd_done) begin
                        state    <= S_IDLE;
                        rd_grant <= 1'b0;
                    end
                end
                default: begin
                    if (rf_done) begin
                        state    <= S_IDLE;
                        rf_grant <= 1'b0;
                    end
                end
            endcase
        end
    end

    // NOTE: every output gets its idle value first so no path through the case
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        array_banksel_n = 1'b1;
        array_raddr     = '0;
        array_cas       = 1'b0;
        array_caddr     = '0;
        array_we        = 1'b0;
        case (state)
            S_WR: begin
                array_banksel_n = banksel_n_wr;
                array_raddr     = raddr_wr;
                array_cas       = cas_wr;
                array_caddr     = caddr_wr;
                array_we        = 1'b1;
            end
            S_RD: begin
                array_banksel_n = banksel_n_rd;
                array_raddr     = raddr_rd;
                array_cas       = cas_rd;
                array_caddr     = caddr_rd;
            end
            S_RF: begin
                array_banksel_n = banksel_n_rf;
                array_raddr     = raddr_rf;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_array_access_sched.sv
// Directed bench for array_access_sched: refresh timing, round-robin, refresh
// priority, pending-counter saturation/drain, array mux and asynchronous reset.
`timescale 1ns/1ps

module tb_array_access_sched;

    logic        clk;
    logic        rst_n;
    logic [15:0] mc_trefi_cfg;
    logic        wr_req, rd_req, wr_done, rd_done, rf_done;
    logic        wr_grant, rd_grant, rf_grant;
    logic [3:0]  rf_pend_cnt;
    logic        rf_overflow;
    logic        banksel_n_wr, cas_wr, banksel_n_rd, cas_rd, banksel_n_rf;
    logic [13:0] raddr_wr, raddr_rd, raddr_rf;
    logic [5:0]  caddr_wr, caddr_rd;
    logic        array_banksel_n, array_cas, array_we;
    logic [13:0] array_raddr;
    logic [5:0]  array_caddr;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] G_NONE = 3'b000;
    localparam logic [2:0] G_WR   = 3'b100;
    localparam logic [2:0] G_RD   = 3'b010;
    localparam logic [2:0] G_RF   = 3'b001;

    array_access_sched #(
        .AXI_RADDR_WIDTH(14),
        .AXI_CADDR_WIDTH(6),
        .RF_PEND_MAX(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mc_trefi_cfg(mc_trefi_cfg),
        .wr_req(wr_req), .rd_req(rd_req),
        .wr_done(wr_done), .rd_done(rd_done), .rf_done(rf_done),
        .wr_grant(wr_grant), .rd_grant(rd_grant), .rf_grant(rf_grant),
        .rf_pend_cnt(rf_pend_cnt), .rf_overflow(rf_overflow),
        .banksel_n_wr(banksel_n_wr), .raddr_wr(raddr_wr), .cas_wr(cas_wr), .caddr_wr(caddr_wr),
        .banksel_n_rd(banksel_n_rd), .raddr_rd(raddr_rd), .cas_rd(cas_rd), .caddr_rd(caddr_rd),
        .banksel_n_rf(banksel_n_rf), .raddr_rf(raddr_rf),
        .array_banksel_n(array_banksel_n), .array_raddr(array_raddr),
        .array_cas(array_cas), .array_caddr(array_caddr), .array_we(array_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_grants(input string tag, input logic [2:0] exp);
        check(tag, 32'({wr_grant, rd_grant, rf_grant}), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // Called on the grant cycle; the done pulse is sampled 5 edges after the grant.
    task automatic serve(input logic [2:0] owner, input string tag);
        steps(4);
        check_grants({tag, "_held"}, owner);
        if (owner == G_WR) wr_done = 1'b1;
        if (owner == G_RD) rd_done = 1'b1;
        if (owner == G_RF) rf_done = 1'b1;
        step();
        wr_done = 1'b0;
        rd_done = 1'b0;
        rf_done = 1'b0;
        check_grants({tag, "_dead"}, G_NONE);
    endtask

    logic [3:0] drain_exp [9] = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd2, 4'd1, 4'd0};

    initial begin
        rst_n        = 1'b0;
        mc_trefi_cfg = 16'd100;
        wr_req = 1'b0; rd_req = 1'b0;
        wr_done = 1'b0; rd_done = 1'b0; rf_done = 1'b0;
        banksel_n_wr = 1'b0; raddr_wr = 14'h1ABC; cas_wr = 1'b1; caddr_wr = 6'h2A;
        banksel_n_rd = 1'b0; raddr_rd = 14'h2345; cas_rd = 1'b1; caddr_rd = 6'h15;
        banksel_n_rf = 1'b0; raddr_rf = 14'h0055;

        // Reset state, with every requester driving non-idle array signals
        #12;
        check_grants("rst_grants", G_NONE);
        check("rst_pend", 32'(rf_pend_cnt), 0);
        check("rst_ovf", 32'(rf_overflow), 0);
        check("rst_banksel_n", 32'(array_banksel_n), 1);
        check("rst_raddr", 32'(array_raddr), 0);
        check("rst_cas", 32'(array_cas), 0);
        check("rst_caddr", 32'(array_caddr), 0);
        check("rst_we", 32'(array_we), 0);
        step();
        rst_n = 1'b1;

        // Refresh interval 100: tick before edge 100, grant at edge 101
        steps(99);
        check("rf_pend_pre_tick", 32'(rf_pend_cnt), 0);
        step();
        check("rf_pend_tick", 32'(rf_pend_cnt), 1);
        check_grants("rf_not_yet", G_NONE);
        step();
        check_grants("rf_grant1", G_RF);
        check("rf_pend_taken", 32'(rf_pend_cnt), 0);
        check("rf_mux_raddr", 32'(array_raddr), 32'h0055);
        check("rf_mux_banksel", 32'(array_banksel_n), 0);
        check("rf_mux_cas", 32'(array_cas), 0);
        check("rf_mux_caddr", 32'(array_caddr), 0);
        check("rf_mux_we", 32'(array_we), 0);
        steps(9);
        rf_done = 1'b1;
        step();
        rf_done = 1'b0;
        check_grants("rf_release", G_NONE);
        check("idle_banksel_n", 32'(array_banksel_n), 1);
        steps(89);
        check("rf_pend_tick2", 32'(rf_pend_cnt), 1);
        check_grants("rf_not_yet2", G_NONE);
        step();
        check_grants("rf_grant2", G_RF);
        rf_done      = 1'b1;
        mc_trefi_cfg = 16'd0;
        step();
        rf_done = 1'b0;
        check_grants("rf_release2", G_NONE);

        // Round-robin with both requests held
        wr_req = 1'b1;
        rd_req = 1'b1;
        step();
        check_grants("rr_1_wr", G_WR);
        check("wr_mux_raddr", 32'(array_raddr), 32'h1ABC);
        check("wr_mux_we", 32'(array_we), 1);
        check("wr_mux_banksel", 32'(array_banksel_n), 0);
        check("wr_mux_caddr", 32'(array_caddr), 32'h2A);
        check("wr_mux_cas_hi", 32'(array_cas), 1);
        cas_wr = 1'b0;
        #1;
        check("wr_mux_cas_lo", 32'(array_cas), 0);
        serve(G_WR, "rr_1");
        step();
        check_grants("rr_2_rd", G_RD);
        serve(G_RD, "rr_2");
        step();
        check_grants("rr_3_wr", G_WR);
        serve(G_WR, "rr_3");
        step();
        check_grants("rr_4_rd", G_RD);
        check("rd_mux_raddr", 32'(array_raddr), 32'h2345);
        check("rd_mux_we", 32'(array_we), 0);
        check("rd_mux_cas", 32'(array_cas), 1);
        check("rd_mux_caddr", 32'(array_caddr), 32'h15);
        wr_req = 1'b0;
        rd_req = 1'b0;
        serve(G_RD, "rr_4");
        step();
        check_grants("rr_idle", G_NONE);

        // Refresh tick during WR queues without preempting; RF then beats RD
        wr_req = 1'b1;
        step();
        check_grants("pri_wr", G_WR);
        mc_trefi_cfg = 16'd3;
        rd_req       = 1'b1;
        steps(2);
        check("pri_pend_pre", 32'(rf_pend_cnt), 0);
        step();
        check("pri_pend_queued", 32'(rf_pend_cnt), 1);
        check_grants("pri_no_preempt", G_WR);
        mc_trefi_cfg = 16'd0;
        rd_done = 1'b1;
        rf_done = 1'b1;
        step();
        rd_done = 1'b0;
        rf_done = 1'b0;
        check_grants("pri_foreign_done", G_WR);
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        wr_req  = 1'b0;
        check_grants("pri_dead", G_NONE);
        step();
        check_grants("pri_rf_first", G_RF);
        check("pri_pend_taken", 32'(rf_pend_cnt), 0);
        rf_done = 1'b1;
        step();
        rf_done = 1'b0;
        check_grants("pri_rf_release", G_NONE);
        step();
        check_grants("pri_rd_after", G_RD);

        // Saturation: read held 50 cycles while ticks arrive every 4 cycles
        mc_trefi_cfg = 16'd4;
        steps(31);
        check("ovf_pend_7", 32'(rf_pend_cnt), 7);
        step();
        check("ovf_pend_8", 32'(rf_pend_cnt), 8);
        check("ovf_not_yet", 32'(rf_overflow), 0);
        steps(4);
        check("ovf_set", 32'(rf_overflow), 1);
        check("ovf_pend_hold", 32'(rf_pend_cnt), 8);
        steps(14);
        check_grants("ovf_rd_held", G_RD);
        check("ovf_pend_end", 32'(rf_pend_cnt), 8);
        rd_done      = 1'b1;
        rd_req       = 1'b0;
        mc_trefi_cfg = 16'd16;
        step();
        rd_done = 1'b0;
        check_grants("drain_start_idle", G_NONE);

        // Drain: one RF every 2 cycles; the tick landing on the 7th grant nets to zero
        for (int i = 0; i < 9; i++) begin
            step();
            check_grants($sformatf("drain_%0d_grant", i), G_RF);
            check($sformatf("drain_%0d_pend", i), 32'(rf_pend_cnt), 32'(drain_exp[i]));
            rf_done = 1'b1;
            step();
            rf_done = 1'b0;
            check_grants($sformatf("drain_%0d_rel", i), G_NONE);
        end
        mc_trefi_cfg = 16'd0;
        step();
        check_grants("drain_done_idle", G_NONE);
        check("drain_done_pend", 32'(rf_pend_cnt), 0);
        check("ovf_sticky", 32'(rf_overflow), 1);

        // Asynchronous reset in the middle of a read access
        rd_req = 1'b1;
        step();
        check_grants("rst_mid_rd", G_RD);
        mc_trefi_cfg = 16'd2;
        steps(4);
        check("rst_mid_pend", 32'(rf_pend_cnt), 2);
        rst_n = 1'b0;
        #1;
        check_grants("rst_mid_grants", G_NONE);
        check("rst_mid_banksel", 32'(array_banksel_n), 1);
        check("rst_mid_pend0", 32'(rf_pend_cnt), 0);
        check("rst_mid_ovf", 32'(rf_overflow), 0);
        check("rst_mid_we", 32'(array_we), 0);
        mc_trefi_cfg = 16'd0;
        wr_req       = 1'b1;
        rd_req       = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_grants("post_rst_wr_first", G_WR);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
